rom_stream_reader: RTL and testbench

- Upstream controller for the single-port synchronous ROM: it generates `en`/address sequences and captures the ROM's registered read data.
- It presents that data as a valid/ready stream with full backpressure support.
- A command (`start`, `start_addr`, `count`) reads `count` consecutive words with address wrap-around, then pulses `done`.
- Sits between the ROM and any stream consumer (UART TX, DAC feeder, pattern generator).

---
 rtl/rom_stream_reader.sv | 141 ++++++++++++++
 tb/tb_rom_stream_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: drives a single-port synchronous ROM with en/address
// bursts and re-presents the registered read data as a valid/ready stream.
// A small FIFO plus a credit check on issue gives full backpressure support.
// Optional feature: define ROM_STREAM_READER_CHKSUM_EN to add a running XOR
// checksum output (chksum) over the words transferred in the current command.
module rom_stream_reader #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ROM_STREAM_READER_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] chksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                inflight_q;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fcnt_q;
    logic [CNT_W:0]      credits_used;
    logic                credit_ok;
    logic                push, pop;
    logic                start_acc;

    assign push         = inflight_q;
    assign out_valid    = (fcnt_q != '0);
    assign pop          = out_valid && out_ready;
    assign out_data     = mem[rd_ptr_q];
    assign rom_addr     = addr_q;
    assign credits_used = {1'b0, fcnt_q} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok    = credits_used < (CNT_W+1)'(FIFO_DEPTH);

    // Next-state, ROM issue and status outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rom_en    = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (count != '0) begin
                        addr_d  = start_addr;
                        rem_d   = count;
                        state_d = ISSUE;
                    end else begin
                        // Zero-length command passes through DRAIN (already empty),
                        // so done lands two cycles after the start cycle.
                        state_d = DRAIN;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    rom_en = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == 1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the last word is popped so done follows it directly.
                if (!inflight_q && ((fcnt_q == '0) || ((fcnt_q == 1) && pop)))
                    state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, read-in-flight flag and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= rom_en;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // FIFO storage; a read returning across reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr_q] <= rom_data;
    end

`ifdef ROM_STREAM_READER_CHKSUM_EN
    logic [DATA_W-1:0] chksum_q;
    assign chksum = chksum_q;

    // Running XOR of transferred words, restarted by each accepted command.
    always_ff @(posedge clk) begin
        if (rst || start_acc) chksum_q <= '0;
        else if (pop)         chksum_q <= chksum_q ^ out_data;
    end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader with a 1-cycle registered ROM
// model (mem[a] = 8'hA0 | a) and scoreboard queues for addresses and words.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_addr = '0;
    logic [3:0] count = '0;
    logic       busy, done, rom_en;
    logic [2:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef ROM_STREAM_READER_CHKSUM_EN
    logic [7:0] chksum;
`endif

    rom_stream_reader #(.ADDR_W(3), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .count(count), .busy(busy), .done(done), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef ROM_STREAM_READER_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= 8'hA0 | {5'b0, rom_addr};

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] exp_x;
    int en_cnt, en_first, en_last, xf_cnt, xf_first, xf_last, done_cnt;
    int s_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: compares ROM addresses and stream words against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                en_cnt++;
                if (exp_addr.size() == 0) check("rom_extra", 32'd1, 32'd0);
                else check("rom_addr", rom_addr, exp_addr.pop_front());
            end
            if (out_valid && out_ready) begin
                if (xf_cnt == 0) xf_first = cyc;
                xf_last = cyc;
                xf_cnt++;
                if (exp_data.size() == 0) check("stream_extra", 32'd1, 32'd0);
                else check("stream_data", out_data, exp_data.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [2:0] a, input logic [3:0] n);
        logic [2:0] ad;
        ad = a;
        exp_x = '0;
        for (int unsigned i = 0; i < n; i++) begin
            exp_addr.push_back(ad);
            exp_data.push_back(8'hA0 | {5'b0, ad});
            exp_x ^= (8'hA0 | {5'b0, ad});
            ad = ad + 3'd1;
        end
        en_cnt = 0; xf_cnt = 0; done_cnt = 0;
        start_addr = a; count = n; start = 1'b1; s_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            step();
        end
        if (dc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Checks done timing, busy around done, checksum and scoreboard closure.
    task automatic finish_cmd(input string nm, input int lat, input int n);
        int dc;
        wait_done(dc);
        if (lat >= 0) check({nm, "_done_lat"}, dc - s_cyc, lat);
        check({nm, "_busy_at_done"}, busy, 1'b1);
`ifdef ROM_STREAM_READER_CHKSUM_EN
        check({nm, "_chksum"}, chksum, exp_x);
`endif
        step();
        check({nm, "_busy_after"}, busy, 1'b0);
        repeat (3) step();
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_rom_reads"}, en_cnt, n);
        check({nm, "_words"}, xf_cnt, n);
        check({nm, "_sb_left"}, exp_data.size(), 0);
    endtask

    initial begin
        int k;
        // Reset state
        en_cnt = 0; xf_cnt = 0; done_cnt = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rom_en", rom_en, 1'b0);
        check("rst_rom_addr", rom_addr, 3'd0);
        check("rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        step();

        // Reset in the middle of a burst, during the 4th read
        out_ready = 1'b1;
        start_cmd(3'd0, 4'd8);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (rom_en) k++;
            if (k == 4) break;
            step();
        end
        check("midrst_reads_seen", k, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_rom_en", rom_en, 1'b0);
        step(); step();
        start_cmd(3'd2, 4'd3);
        finish_cmd("after_rst", 6, 3);

        // Basic full burst with out_ready held high
        start_cmd(3'd0, 4'd8);
        finish_cmd("basic", 11, 8);
        check("basic_en_consec", en_last - en_first, 7);
        check("basic_en_first", en_first - s_cyc, 1);
        check("basic_xf_consec", xf_last - xf_first, 7);
        check("basic_xf_first", xf_first - s_cyc, 3);

        // Address wrap-around
        start_cmd(3'd6, 4'd4);
        finish_cmd("wrap", 7, 4);

        // Backpressure: out_ready low for 10 cycles from the start cycle
        out_ready = 1'b0;
        step();
        start_cmd(3'd0, 4'd8);
        repeat (9) step();
        check("bp_reads_stalled", en_cnt, 4);
        check("bp_valid", out_valid, 1'b1);
        check("bp_head", out_data, 8'hA0);
        out_ready = 1'b1;
        finish_cmd("bp", -1, 8);

        // Zero-length command: no ROM access
        start_cmd(3'd5, 4'd0);
        finish_cmd("zero", 2, 0);

        // A start while busy is ignored
        start_cmd(3'd1, 4'd3);
        start_addr = 3'd4; count = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        finish_cmd("busy_start", 6, 3);

        // Short command whose checksum is A1^A2
        start_cmd(3'd1, 4'd2);
        finish_cmd("short", 5, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks);
        $fatal(1);
    end

endmodule
